// File: rtl/ascii_operand_parser_pkg.sv
// Shared constants and state encoding for the ASCII operand decode path.
// Imported by the character classifier and the frame parser.
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SEVEN = 8'h37;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
  localparam logic [1:0] ERR_SHORT    = 2'b10;
  localparam logic [1:0] ERR_LONG     = 2'b11;

  localparam logic [2:0] FRAME_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/ascii_operand_parser_char_class.sv
// Combinational byte classifier: exactly one of digit/term/space/bad is set.
// The terminator wins over every other class so a custom TERM_CHAR is never shadowed.
module ascii_char_class
  import ascii_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR  = ASCII_CR,
  parameter bit         SKIP_SPACE = 1'b1
) (
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_space,
  output logic       is_bad,
  output logic [2:0] digit_val
);

  always_comb begin
    is_term   = (char_in == TERM_CHAR);
    is_digit  = !is_term && (char_in >= ASCII_ZERO) && (char_in <= ASCII_SEVEN);
    is_space  = !is_term && SKIP_SPACE && (char_in == ASCII_SPACE);
    is_bad    = !(is_term || is_digit || is_space);
    digit_val = char_in[2:0];
  end

endmodule

// File: rtl/ascii_operand_parser.sv
// Decodes frames of four ASCII octal digits plus terminator into operands A..D.
// Rejected frames pulse err and leave the previously presented operands untouched.
module ascii_operand_parser
  import ascii_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR  = ASCII_CR,
  parameter bit         SKIP_SPACE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] C,
  output logic [2:0] D,
  output logic       operands_valid,
  output logic       err,
  output logic [1:0] err_code
);

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic [3:0][2:0] stage, stage_nxt;
  logic            load;
  logic            err_nxt;
  logic [1:0]      code_nxt;
  logic            accept;

  logic            is_digit, is_term, is_space, is_bad;
  logic [2:0]      digit_val;

  ascii_char_class #(
    .TERM_CHAR (TERM_CHAR),
    .SKIP_SPACE(SKIP_SPACE)
  ) u_class (
    .char_in  (char_in),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_space (is_space),
    .is_bad   (is_bad),
    .digit_val(digit_val)
  );

  // The one-cycle PRESENT bubble is the only time a byte is refused.
  assign char_ready = (state != PRESENT);
  assign accept     = char_valid && char_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage;
    load      = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;

    case (state)
      COLLECT: begin
        if (accept) begin
          if (is_term) begin
            if (cnt == FRAME_DIGITS) begin
              state_nxt = PRESENT;
              load      = 1'b1;
            end else begin
              err_nxt  = 1'b1;
              code_nxt = ERR_SHORT;
              cnt_nxt  = 3'd0;
            end
          end else if (is_digit) begin
            if (cnt == FRAME_DIGITS) begin
              err_nxt   = 1'b1;
              code_nxt  = ERR_LONG;
              state_nxt = DRAIN;
            end else begin
              stage_nxt[cnt[1:0]] = digit_val;
              cnt_nxt             = cnt + 3'd1;
            end
          end else if (is_bad) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_BAD_CHAR;
            state_nxt = DRAIN;
          end
        end
      end
      PRESENT: begin
        state_nxt = COLLECT;
        cnt_nxt   = 3'd0;
      end
      DRAIN: begin
        // Everything up to the terminator is swallowed without further errors.
        if (accept && is_term) begin
          state_nxt = COLLECT;
          cnt_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = COLLECT;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Operands load on the terminator edge so they appear together with operands_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= COLLECT;
      cnt            <= 3'd0;
      stage          <= '0;
      A              <= 3'd0;
      B              <= 3'd0;
      C              <= 3'd0;
      D              <= 3'd0;
      operands_valid <= 1'b0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      stage          <= stage_nxt;
      operands_valid <= load;
      err            <= err_nxt;
      err_code       <= code_nxt;
      if (load) begin
        A <= stage[0];
        B <= stage[1];
        C <= stage[2];
        D <= stage[3];
      end
    end
  end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Randomised and directed bench for ascii_operand_parser, with SKIP_SPACE on and off.
// A frame-level reference model predicts every output each cycle.
module tb_ascii_operand_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;

  logic       rdy [2];
  logic [2:0] a_o [2];
  logic [2:0] b_o [2];
  logic [2:0] c_o [2];
  logic [2:0] d_o [2];
  logic       val_o [2];
  logic       err_o [2];
  logic [1:0] code_o [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, one copy per instance
  bit         skip_en [2];
  bit         m_ready [2];
  bit         m_valid [2];
  bit         m_err [2];
  logic [1:0] m_code [2];
  logic [2:0] m_ops [2][4];
  logic [2:0] m_frame [2][4];
  int         m_len [2];
  bit         m_dead [2];

  always #5 clk = ~clk;

  ascii_operand_parser dut0 (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(rdy[0]), .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]),
    .operands_valid(val_o[0]), .err(err_o[0]), .err_code(code_o[0])
  );

  ascii_operand_parser #(.SKIP_SPACE(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(rdy[1]), .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]),
    .operands_valid(val_o[1]), .err(err_o[1]), .err_code(code_o[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset(input int i);
    m_ready[i] = 1'b1;
    m_valid[i] = 1'b0;
    m_err[i]   = 1'b0;
    m_code[i]  = 2'b00;
    m_len[i]   = 0;
    m_dead[i]  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_ops[i][k]   = 3'd0;
      m_frame[i][k] = 3'd0;
    end
  endfunction

  function automatic void modelByte(input int i, input logic [7:0] b);
    bit is_t, is_d, is_s;
    int v;
    is_t = (b == 8'h0D);
    is_d = (b >= 8'h30) && (b <= 8'h37);
    is_s = skip_en[i] && (b == 8'h20);
    v    = int'(b) - 48;
    if (m_dead[i]) begin
      if (is_t) begin
        m_dead[i] = 1'b0;
        m_len[i]  = 0;
      end
    end else if (is_t) begin
      if (m_len[i] == 4) begin
        for (int k = 0; k < 4; k++) m_ops[i][k] = m_frame[i][k];
        m_valid[i] = 1'b1;
        m_ready[i] = 1'b0;
      end else begin
        m_err[i]  = 1'b1;
        m_code[i] = 2'b10;
      end
      m_len[i] = 0;
    end else if (is_d) begin
      if (m_len[i] == 4) begin
        m_err[i]  = 1'b1;
        m_code[i] = 2'b11;
        m_dead[i] = 1'b1;
      end else begin
        m_frame[i][m_len[i]] = v[2:0];
        m_len[i]++;
      end
    end else if (!is_s) begin
      m_err[i]  = 1'b1;
      m_code[i] = 2'b01;
      m_dead[i] = 1'b1;
    end
  endfunction

  // Drives one cycle of input, advances the model and compares every output
  task automatic applyStimulus(input logic [7:0] b, input bit v, output bit acc0);
    bit acc [2];
    char_in    = b;
    char_valid = v;
    for (int i = 0; i < 2; i++) acc[i] = v && m_ready[i] && rst_n;
    acc0 = acc[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_err[i]   = 1'b0;
      m_ready[i] = 1'b1;
      if (!rst_n) modelReset(i);
      else if (acc[i]) modelByte(i, b);
      checkOutput($sformatf("d%0d_ready", i), 32'(rdy[i]), 32'(m_ready[i]));
      checkOutput($sformatf("d%0d_valid", i), 32'(val_o[i]), 32'(m_valid[i]));
      checkOutput($sformatf("d%0d_err", i), 32'(err_o[i]), 32'(m_err[i]));
      checkOutput($sformatf("d%0d_code", i), 32'(code_o[i]), 32'(m_code[i]));
      checkOutput($sformatf("d%0d_ops", i), {20'd0, a_o[i], b_o[i], c_o[i], d_o[i]},
                  {20'd0, m_ops[i][0], m_ops[i][1], m_ops[i][2], m_ops[i][3]});
    end
  endtask

  task automatic sendChars(input string s, input bit add_term, input bit rand_valid);
    bit got;
    int guard;
    for (int k = 0; k <= s.len(); k++) begin
      logic [7:0] b;
      if (k == s.len()) begin
        if (!add_term) break;
        b = 8'h0D;
      end else begin
        b = s[k];
      end
      got   = 1'b0;
      guard = 0;
      while (!got && guard < 40) begin
        applyStimulus(b, rand_valid ? bit'($urandom_range(0, 1)) : 1'b1, got);
        guard++;
      end
      checkOutput("byte_accept", 32'(got), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    bit got;
    for (int k = 0; k < n; k++) applyStimulus(8'h00, 1'b0, got);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    skip_en[0] = 1'b1;
    skip_en[1] = 1'b0;
    for (int i = 0; i < 2; i++) modelReset(i);

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    sendChars("3075", 1'b1, 1'b0);
    idle(2);
    sendChars("1922", 1'b1, 1'b0);
    sendChars("4444", 1'b1, 1'b0);
    idle(1);
    sendChars("12", 1'b1, 1'b0);
    sendChars("12345", 1'b1, 1'b0);
    idle(2);
    sendChars("6 1 23", 1'b1, 1'b1);
    idle(2);
    sendChars("55", 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(8'h35, 1'b1, got);
    rst_n = 1'b1;
    sendChars("0123", 1'b1, 1'b0);
    idle(1);
    sendChars("7654", 1'b1, 1'b0);
    sendChars("2107", 1'b1, 1'b0);
    idle(2);

    for (int n = 0; n < 2000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'h30 + 8'($urandom_range(0, 7));
      else if (r < 72) b = 8'h0D;
      else if (r < 80) b = 8'h20;
      else if (r < 86) b = 8'h38 + 8'($urandom_range(0, 1));
      else             b = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 249) != 0);
      applyStimulus(b, $urandom_range(0, 3) != 0, got);
    end
    rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_operand_parser.md
# ascii_operand_parser

Receives a byte stream of ASCII characters over a valid/ready handshake and decodes each frame of four octal digits into the four 3-bit operands A, B, C, D used by the minimum-index comparator. It is the decode end of the ASCII path. The comparator emits its result as an ASCII digit (8'h30 + index); this block turns incoming ASCII digits back into binary operands. Malformed frames are rejected with an error pulse, and the last good operands are kept.

## Interface
- TERM_CHAR, default 8'h0D: frame terminator byte (CR).
- SKIP_SPACE, default 1: when 1, byte 8'h20 is silently accepted and ignored anywhere in a frame.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset; sampled on posedge clk.
- char_in  input  8  incoming ASCII byte.
- char_valid  input  1  char_in holds a byte.
- char_ready  output  1  parser can accept a byte this cycle.
- A, B, C, D  output  3 each  last successfully decoded operands.
- operands_valid  output  1  one-cycle pulse: A..D were just updated.
- err  output  1  one-cycle pulse: frame rejected.
- err_code  output  2  cause of the last rejection, held until the next err: 01 BAD_CHAR, 10 SHORT, 11 LONG.

## Operation
- A byte is accepted on a posedge where char_valid && char_ready. No other byte has any effect.
- Digit classification: 8'h30..8'h37 is a digit with value char_in[2:0]. TERM_CHAR is the terminator. 8'h20 with SKIP_SPACE=1 is a space. Every other byte is bad, including '8', '9' and 8'h20 when SKIP_SPACE=0.
- States:
  - COLLECT, with digit count cnt 0..4. Reset enters COLLECT with cnt=0.
  - PRESENT.
  - DRAIN.
- In COLLECT:
  - digit, cnt<4: store the value in staging slot cnt, then cnt++. Slot order is A, B, C, D.
  - digit, cnt==4: err with LONG, go to DRAIN.
  - space: no change.
  - bad byte: err with BAD_CHAR, go to DRAIN.
  - terminator, cnt==4: go to PRESENT.
  - terminator, cnt<4: err with SHORT, cnt=0, stay in COLLECT. This includes an empty frame.
- PRESENT lasts exactly one cycle. A..D load from staging, operands_valid=1, char_ready=0. The block then goes to COLLECT with cnt=0.
- In DRAIN, all bytes are accepted and discarded until a terminator. The terminator is consumed, and the block goes to COLLECT with cnt=0. No further err pulse is raised while in DRAIN.
- Staging is separate from A..D, so a rejected frame never alters A..D.

## Timing
- Reset values:
  - A = B = C = D = 0.
  - operands_valid = 0, err = 0, err_code = 00.
  - char_ready = 1.
  - state COLLECT, cnt = 0.
- char_ready is 1 in COLLECT and DRAIN and 0 only in PRESENT. It is registered/state-derived and does not depend on char_valid.
- Latency: the terminator is accepted at edge N, then operands_valid=1 and new A..D are visible in cycle N+1. The earliest next byte is accepted at edge N+2.
- err is asserted in the cycle after the offending byte is accepted. err_code updates in the same cycle.
- Back-to-back frames sustain one byte per cycle, with one bubble per good frame.
- If rst_n is low at an edge mid-frame or in PRESENT, the block returns to reset values. Any pending operands_valid is suppressed and staging is discarded.
- err and operands_valid are never high in the same cycle.

## Structure
- Package ascii_pkg holds:
  - ASCII_ZERO = 8'h30, ASCII_SEVEN = 8'h37, ASCII_SPACE = 8'h20, ASCII_CR = 8'h0D.
  - the err_code localparams ERR_BAD_CHAR, ERR_SHORT, ERR_LONG.
  - the state encoding COLLECT, PRESENT, DRAIN.
- One combinational sub-module, ascii_char_class. Input: char_in and SKIP_SPACE. Outputs: is_digit, is_term, is_space, is_bad, digit_val[2:0]. The top level holds the FSM, counter, staging and output registers.

## Test plan
- Good frame: bytes "3","0","7","5",CR at one per cycle -> one cycle after CR, operands_valid=1 with A=3, B=0, C=7, D=5, char_ready=0 in that cycle.
- Bad character: "1","9","2","2",CR -> err=1, err_code=01 one cycle after "9". No operands_valid. A..D keep prior values. The next "4","4","4","4",CR gives A..D=4.
- Short and long: "1","2",CR -> err, code 10. Then "1","2","3","4","5",CR -> err, code 11 after "5"; CR is drained without a second err.
- Spaces and handshake: "6"," ","1"," ","2","3",CR with char_valid toggled randomly -> A=6, B=1, C=2, D=3. With SKIP_SPACE=0 the same stream gives err code 01.
- Reset mid-frame: "5","5" then rst_n=0 for one edge -> outputs at reset values. Then "0","1","2","3",CR -> A=0, B=1, C=2, D=3.
- Back-to-back: two good frames streamed continuously -> two operands_valid pulses, with exactly one stalled cycle (char_ready=0) after each CR.
